// File: rtl/xgmac_pkg.sv
// ---------------------------------------------------------------------------
// xgmac_pkg
// Shared types and helpers for the 10G MAC receive buffer.
//   wr_state_e      : write-side frame FSM states
//   pause_state_e   : flow-control FSM states
//   XGMAC_PAUSE_OFF : pause quanta value that releases the link partner
//   xgmac_keep_width: byte-enable width for a given stream data width
// ---------------------------------------------------------------------------
package xgmac_pkg;

    typedef enum logic {
        WR_FRAME = 1'b0,
        WR_DROP  = 1'b1
    } wr_state_e;

    typedef enum logic {
        P_XON  = 1'b0,
        P_XOFF = 1'b1
    } pause_state_e;

    localparam logic [15:0] XGMAC_PAUSE_OFF = 16'h0000;

    function automatic int unsigned xgmac_keep_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/xgmac_fifo_ram.sv
// ---------------------------------------------------------------------------
// xgmac_fifo_ram
// Single-clock simple dual-port RAM: synchronous write, registered read.
// The read register only loads when re_i is high, so rdata_o holds its
// value while the consumer stalls.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable (loads the read register)
//   raddr_i : read address
//   rdata_o : registered read data
// ---------------------------------------------------------------------------
module xgmac_fifo_ram
    import xgmac_pkg::*;
#(
    parameter int unsigned WIDTH  = 73,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1 << ADDR_W)-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/xgmac_rx_pause_fifo.sv
// ---------------------------------------------------------------------------
// xgmac_rx_pause_fifo
// Store-and-forward receive buffer between the 10G MAC receive stream and
// user logic. Only complete good frames are released; bad frames and frames
// that overflow the buffer are rewound and reported on frame_drop. The
// buffer occupancy drives XOFF/XON pause requests with periodic XOFF refresh.
//
// Ports:
//   clk156, rx_axis_aresetn : clock, synchronous active-low reset
//   s_axis_*                : MAC receive stream (no backpressure)
//   m_axis_*                : user stream with tready backpressure
//   pause_req, pause_val    : pause pulse and quanta to the MAC
//   fifo_level              : occupied beats, committed plus in-progress
//   frame_drop              : one-cycle pulse per discarded frame
//
// Optional feature: define XGMAC_RX_PAUSE_FIFO_STATS_EN to add the saturating
// frame_count / drop_count outputs.
// ---------------------------------------------------------------------------
module xgmac_rx_pause_fifo
    import xgmac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned DEPTH_LOG2     = 9,
    parameter int unsigned HI_WM          = 384,
    parameter int unsigned LO_WM          = 128,
    parameter logic [15:0] PAUSE_QUANTA   = 16'hFFFF,
    parameter int unsigned REFRESH_CYCLES = 4096
) (
    input  logic                                  clk156,
    input  logic                                  rx_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
    input  logic [xgmac_keep_width(DATA_WIDTH)-1:0] s_axis_tkeep,
    input  logic                                  s_axis_tvalid,
    input  logic                                  s_axis_tlast,
    input  logic                                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [xgmac_keep_width(DATA_WIDTH)-1:0] m_axis_tkeep,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
    output logic                                  pause_req,
    output logic [15:0]                           pause_val,
    output logic [DEPTH_LOG2:0]                   fifo_level,
    output logic                                  frame_drop
`ifdef XGMAC_RX_PAUSE_FIFO_STATS_EN
    ,
    output logic [31:0]                           frame_count,
    output logic [31:0]                           drop_count
`endif
);

    localparam int unsigned KEEP_W = xgmac_keep_width(DATA_WIDTH);
    localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
    localparam int unsigned WORD_W = DATA_WIDTH + KEEP_W + 1;
    localparam int unsigned CNT_W  = $clog2(REFRESH_CYCLES);

    localparam logic [PTR_W-1:0] FULL_LEVEL = PTR_W'(2 ** DEPTH_LOG2);
    localparam logic [PTR_W-1:0] HI_LEVEL   = PTR_W'(HI_WM);
    localparam logic [PTR_W-1:0] LO_LEVEL   = PTR_W'(LO_WM);
    localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(REFRESH_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Pointers and write FSM
    // -----------------------------------------------------------------------
    wr_state_e        wr_state_q, wr_state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             frame_drop_q, drop_d;
    logic             ram_we;
    logic             full;

    // Full is judged on the pre-edge pointers, before any same-cycle read.
    assign full = ((wr_ptr_q - rd_ptr_q) == FULL_LEVEL);

    always_ff @(posedge clk156) begin
        if (!rx_axis_aresetn) begin
            wr_state_q <= WR_FRAME;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_FRAME: begin
                if (s_axis_tvalid && full && !s_axis_tlast) begin
                    wr_state_d = WR_DROP;
                end
            end
            WR_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    wr_state_d = WR_FRAME;
                end
            end
            default: wr_state_d = WR_FRAME;
        endcase
    end

    always_comb begin
        ram_we       = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_d       = 1'b0;
        if ((wr_state_q == WR_FRAME) && s_axis_tvalid) begin
            if (full) begin
                wr_ptr_d = commit_ptr_q;
                drop_d   = 1'b1;
            end else begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (s_axis_tlast) begin
                    if (s_axis_tuser) begin
                        commit_ptr_d = wr_ptr_q + PTR_W'(1);
                    end else begin
                        wr_ptr_d = commit_ptr_q;
                        drop_d   = 1'b1;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read side: RAM read register (stage 1) feeding a one-entry output
    // register. A read is issued only when stage 1 is empty or is moving into
    // the output register this cycle, so nothing is ever overwritten and a
    // continuously ready sink sees one beat per clock.
    // -----------------------------------------------------------------------
    logic              s1_valid_q, s1_valid_d;
    logic              out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [KEEP_W-1:0] out_keep_q;
    logic              out_last_q;
    logic              avail, out_ready, s1_move, rd_issue;
    logic [WORD_W-1:0] ram_wdata, ram_rdata;

    assign avail      = (rd_ptr_q != commit_ptr_q);
    assign out_ready  = !out_valid_q || m_axis_tready;
    assign s1_move    = s1_valid_q && out_ready;
    assign rd_issue   = avail && (!s1_valid_q || out_ready);
    assign rd_ptr_d   = rd_ptr_q + PTR_W'(rd_issue);
    assign s1_valid_d = rd_issue || (s1_valid_q && !s1_move);
    assign level_d    = wr_ptr_d - rd_ptr_d;
    assign ram_wdata  = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    xgmac_fifo_ram #(
        .WIDTH  (WORD_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk156),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (ram_wdata),
        .re_i    (rd_issue),
        .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk156) begin
        if (!rx_axis_aresetn) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            frame_drop_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            frame_drop_q <= drop_d;
            s1_valid_q   <= s1_valid_d;
            if (s1_move) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ram_rdata[DATA_WIDTH-1:0];
                out_keep_q  <= ram_rdata[DATA_WIDTH +: KEEP_W];
                out_last_q  <= ram_rdata[WORD_W-1];
            end else if (m_axis_tready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign fifo_level    = level_q;
    assign frame_drop    = frame_drop_q;

    // -----------------------------------------------------------------------
    // Pause FSM, driven by the registered level
    // -----------------------------------------------------------------------
    pause_state_e     pause_state_q, pause_state_d;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic             pause_req_q, pause_req_d;
    logic [15:0]      pause_val_q, pause_val_d;

    always_ff @(posedge clk156) begin
        if (!rx_axis_aresetn) begin
            pause_state_q <= P_XON;
        end else begin
            pause_state_q <= pause_state_d;
        end
    end

    always_comb begin
        pause_state_d = pause_state_q;
        case (pause_state_q)
            P_XON: begin
                if (level_q >= HI_LEVEL) begin
                    pause_state_d = P_XOFF;
                end
            end
            P_XOFF: begin
                if (level_q <= LO_LEVEL) begin
                    pause_state_d = P_XON;
                end
            end
            default: pause_state_d = P_XON;
        endcase
    end

    // XON release wins over a refresh expiring in the same cycle.
    always_comb begin
        pause_req_d = 1'b0;
        pause_val_d = pause_val_q;
        refresh_d   = refresh_q;
        case (pause_state_q)
            P_XON: begin
                if (level_q >= HI_LEVEL) begin
                    pause_req_d = 1'b1;
                    pause_val_d = PAUSE_QUANTA;
                    refresh_d   = RELOAD;
                end
            end
            P_XOFF: begin
                if (level_q <= LO_LEVEL) begin
                    pause_req_d = 1'b1;
                    pause_val_d = XGMAC_PAUSE_OFF;
                end else if (refresh_q == '0) begin
                    pause_req_d = 1'b1;
                    pause_val_d = PAUSE_QUANTA;
                    refresh_d   = RELOAD;
                end else begin
                    refresh_d = refresh_q - CNT_W'(1);
                end
            end
            default: begin
                pause_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk156) begin
        if (!rx_axis_aresetn) begin
            refresh_q   <= '0;
            pause_req_q <= 1'b0;
            pause_val_q <= '0;
        end else begin
            refresh_q   <= refresh_d;
            pause_req_q <= pause_req_d;
            pause_val_q <= pause_val_d;
        end
    end

    assign pause_req = pause_req_q;
    assign pause_val = pause_val_q;

`ifdef XGMAC_RX_PAUSE_FIFO_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating statistics; a commit always advances commit_ptr.
    // -----------------------------------------------------------------------
    logic [31:0] frame_count_q, drop_count_q;

    always_ff @(posedge clk156) begin
        if (!rx_axis_aresetn) begin
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            if ((commit_ptr_d != commit_ptr_q) && (frame_count_q != '1)) begin
                frame_count_q <= frame_count_q + 32'd1;
            end
            if (drop_d && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + 32'd1;
            end
        end
    end

    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_xgmac_rx_pause_fifo.sv
// ---------------------------------------------------------------------------
// tb_xgmac_rx_pause_fifo
// Self-checking bench for xgmac_rx_pause_fifo with a 16-beat buffer,
// watermarks 12/4 and a 16-cycle XOFF refresh interval.
// ---------------------------------------------------------------------------
module tb_xgmac_rx_pause_fifo;

    localparam int unsigned DW  = 64;
    localparam int unsigned DL2 = 4;
    localparam int unsigned HI  = 12;
    localparam int unsigned LO  = 4;
    localparam int unsigned RC  = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [DW-1:0]  s_tdata;
    logic [7:0]     s_tkeep;
    logic           s_tvalid, s_tlast, s_tuser;
    logic [DW-1:0]  m_tdata;
    logic [7:0]     m_tkeep;
    logic           m_tvalid, m_tlast, m_tready;
    logic           pause_req;
    logic [15:0]    pause_val;
    logic [DL2:0]   fifo_level;
    logic           frame_drop;
`ifdef XGMAC_RX_PAUSE_FIFO_STATS_EN
    logic [31:0]    frame_count, drop_count;
`endif

    always #5 clk = ~clk;

    xgmac_rx_pause_fifo #(
        .DATA_WIDTH     (DW),
        .DEPTH_LOG2     (DL2),
        .HI_WM          (HI),
        .LO_WM          (LO),
        .PAUSE_QUANTA   (16'hFFFF),
        .REFRESH_CYCLES (RC)
    ) dut (
        .clk156          (clk),
        .rx_axis_aresetn (rst_n),
        .s_axis_tdata    (s_tdata),
        .s_axis_tkeep    (s_tkeep),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tlast    (s_tlast),
        .s_axis_tuser    (s_tuser),
        .m_axis_tdata    (m_tdata),
        .m_axis_tkeep    (m_tkeep),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tlast    (m_tlast),
        .m_axis_tready   (m_tready),
        .pause_req       (pause_req),
        .pause_val       (pause_val),
        .fifo_level      (fifo_level),
        .frame_drop      (frame_drop)
`ifdef XGMAC_RX_PAUSE_FIFO_STATS_EN
        ,
        .frame_count     (frame_count),
        .drop_count      (drop_count)
`endif
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int unsigned cyc;
        logic [15:0] val;
    } pev_t;

    typedef struct {
        int unsigned len;
        logic        tuser;
        logic        deliver;
        int unsigned ndrop;
    } vec_t;

    beat_t       exp_q[$];
    beat_t       got_q[$];
    pev_t        pq[$];
    int unsigned cyc   = 0;
    int unsigned drops = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observers sample mid-cycle; inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) got_q.push_back('{m_tdata, m_tkeep, m_tlast});
        if (pause_req) pq.push_back('{cyc, pause_val});
        if (frame_drop) drops <= drops + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int unsigned id, input int unsigned b, input logic last,
                              input logic tuser, input logic deliver);
        s_tvalid = 1'b1;
        s_tdata  = {32'(id), 32'(b)};
        s_tlast  = last;
        s_tkeep  = last ? 8'h0F : 8'hFF;
        s_tuser  = tuser;
        if (deliver) exp_q.push_back('{s_tdata, s_tkeep, s_tlast});
    endtask

    task automatic idle_inputs();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        s_tkeep  = '0;
        s_tdata  = '0;
    endtask

    task automatic send_frame(input int unsigned id, input int unsigned len,
                              input logic tuser, input logic deliver);
        for (int unsigned b = 0; b < len; b++) begin
            drive_beat(id, b, (b == len - 1), tuser, deliver);
            step();
        end
        idle_inputs();
    endtask

    task automatic drain();
        int unsigned n = 0;
        m_tready = 1'b1;
        while (!(fifo_level == 0 && !m_tvalid) && n < 200) begin
            step();
            n++;
        end
        check("drain_done", n < 200, 1);
        repeat (4) step();
    endtask

    task automatic compare_out(input string name);
        int unsigned mism = 0;
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) mism++;
        end
        check({name, "_beats"}, mism, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    vec_t vt[6];

    initial begin
        int unsigned d0;
        int unsigned n;

        vt[0] = '{8,  1'b0, 1'b0, 1};
        vt[1] = '{1,  1'b1, 1'b1, 0};
        vt[2] = '{16, 1'b1, 1'b1, 0};
        vt[3] = '{17, 1'b1, 1'b0, 1};
        vt[4] = '{5,  1'b0, 1'b0, 1};
        vt[5] = '{2,  1'b1, 1'b1, 0};

        rst_n    = 1'b0;
        m_tready = 1'b0;
        idle_inputs();
        repeat (3) step();
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_level", fifo_level, 0);
        check("rst_pause_req", pause_req, 0);
        check("rst_pause_val", pause_val, 0);
        check("rst_drop", frame_drop, 0);
        rst_n = 1'b1;
        step();

        // Good 8-beat frame: first beat valid two edges after tlast.
        m_tready = 1'b1;
        d0 = drops;
        send_frame(1, 8, 1'b1, 1'b1);
        check("lat_n1_tvalid", m_tvalid, 0);
        step();
        check("lat_n1b_tvalid", m_tvalid, 0);
        step();
        check("lat_n2_tvalid", m_tvalid, 1);
        check("lat_n2_tdata", m_tdata, {32'd1, 32'd0});
        drain();
        compare_out("good8");
        check("good8_drops", drops - d0, 0);

        // Table of single frames with a ready sink.
        for (int unsigned i = 0; i < 6; i++) begin
            d0 = drops;
            send_frame(10 + i, vt[i].len, vt[i].tuser, vt[i].deliver);
            drain();
            compare_out($sformatf("vec%0d", i));
            check($sformatf("vec%0d_drops", i), drops - d0, vt[i].ndrop);
            check($sformatf("vec%0d_level", i), fifo_level, 0);
        end

        // Overflow: 3 committed beats (2 prefetched), then a 20-beat frame.
        m_tready = 1'b0;
        send_frame(20, 3, 1'b1, 1'b1);
        repeat (3) step();
        check("ovf_prior_level", fifo_level, 1);
        check("hold_tvalid", m_tvalid, 1);
        check("hold_tdata", m_tdata, {32'd20, 32'd0});
        d0 = drops;
        send_frame(21, 20, 1'b1, 1'b0);
        step();
        check("ovf_level", fifo_level, 1);
        check("ovf_drops", drops - d0, 1);
        check("hold2_tdata", m_tdata, {32'd20, 32'd0});
        send_frame(22, 4, 1'b1, 1'b1);
        drain();
        compare_out("ovf_out");

        // Pause: XOFF at level 12, refresh, XON release beating the refresh.
        repeat (4) step();
        pq.delete();
        m_tready = 1'b0;
        for (int unsigned b = 0; b < 14; b++) begin
            drive_beat(30, b, (b == 13), 1'b1, 1'b1);
            step();
            if (b == 11) check("xoff_not_early", pause_req, 0);
            if (b == 12) begin
                check("xoff_req", pause_req, 1);
                check("xoff_val", pause_val, 16'hFFFF);
            end
        end
        idle_inputs();
        step();
        n = 0;
        while (!pause_req && n < 40) begin
            step();
            n++;
        end
        check("refresh_seen", pause_req, 1);
        check("refresh_val", pause_val, 16'hFFFF);
        // Now just past the refresh edge P: drain 8 beats on edges P+8..P+15.
        repeat (7) step();
        m_tready = 1'b1;
        repeat (8) step();
        m_tready = 1'b0;
        step();
        check("xon_req", pause_req, 1);
        check("xon_val", pause_val, 16'h0000);
        check("xon_level", fifo_level, LO);
        repeat (10) step();
        check("pause_pulses", pq.size(), 3);
        if (pq.size() >= 3) begin
            check("refresh_interval", pq[1].cyc - pq[0].cyc, RC);
            check("xon_interval", pq[2].cyc - pq[1].cyc, RC);
            check("xon_q_val", pq[2].val, 16'h0000);
        end
        check("xon_val_held", pause_val, 16'h0000);
        drain();
        compare_out("pause_out");

        // Reset mid-frame with committed data pending.
        m_tready = 1'b0;
        send_frame(40, 3, 1'b1, 1'b1);
        drive_beat(41, 0, 1'b0, 1'b1, 1'b0);
        step();
        drive_beat(41, 1, 1'b0, 1'b1, 1'b0);
        step();
        idle_inputs();
        check("pre_rst_level", fifo_level, 3);
        check("pre_rst_tvalid", m_tvalid, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_tvalid", m_tvalid, 0);
        check("mid_rst_level", fifo_level, 0);
        rst_n = 1'b1;
        step();
        got_q.delete();
        exp_q.delete();
        m_tready = 1'b1;
        send_frame(42, 5, 1'b1, 1'b1);
        drain();
        compare_out("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xgmac_rx_pause_fifo.md
# xgmac_rx_pause_fifo

Parametrised receive buffer between the 10G MAC receive AXI-Stream and user logic, replacing the unbuffered MAC-to-user path. The MAC receive stream has no backpressure, so the block stores complete frames and forwards only good, fully stored frames. It drops bad frames and frames that overflow, and drives the MAC `pause_req`/`pause_val` inputs from watermark-based XOFF/XON logic with periodic refresh. It runs on `clk156`, beside `xgmac_int`, which it supersedes as the pause source.

## Interface
Parameters:
- `DATA_WIDTH`, 64, stream width in bits; keep width is DATA_WIDTH/8.
- `DEPTH_LOG2`, 9, log2 of storage depth in beats (512).
- `HI_WM`, 384, XOFF threshold in beats; requires LO_WM < HI_WM <= 2**DEPTH_LOG2.
- `LO_WM`, 128, XON threshold in beats.
- `PAUSE_QUANTA`, 16'hFFFF, value on `pause_val` for XOFF.
- `REFRESH_CYCLES`, 4096, XOFF re-send interval in clocks while still above LO_WM; minimum 2.

Ports:
- `clk156` in 1: the single clock.
- `rx_axis_aresetn` in 1: synchronous active-low reset, sampled on the `clk156` rising edge. The same net resets the MAC receive path.
- `s_axis_tdata` in DATA_WIDTH: data from the MAC.
- `s_axis_tkeep` in DATA_WIDTH/8: byte enables from the MAC.
- `s_axis_tvalid` in 1: beat valid; there is no tready.
- `s_axis_tlast` in 1: last beat of frame.
- `s_axis_tuser` in 1: sampled with tlast; 1 means good frame.
- `m_axis_tdata` out DATA_WIDTH: data to user logic.
- `m_axis_tkeep` out DATA_WIDTH/8: byte enables to user logic.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tlast` out 1: output last beat.
- `m_axis_tready` in 1: user backpressure.
- `pause_req` out 1: one-cycle pulse to the MAC.
- `pause_val` out 16: pause quanta, valid with `pause_req` and held between pulses.
- `fifo_level` out DEPTH_LOG2+1: occupied beats, committed plus in-progress.
- `frame_drop` out 1: one-cycle pulse per discarded frame.

## Operation
- Pointers: `wr_ptr` (speculative), `commit_ptr` and `rd_ptr`, each DEPTH_LOG2+1 bits with natural wrap. Full when wr_ptr − rd_ptr == 2**DEPTH_LOG2.
- Stored word: {tlast, tkeep, tdata}.
- Write FSM has two states, WR_FRAME and WR_DROP; reset state is WR_FRAME.
- WR_FRAME, valid beat, not full: write the beat and increment `wr_ptr`.
  - If tlast and tuser=1: `commit_ptr` <= wr_ptr+1.
  - If tlast and tuser=0: `wr_ptr` <= commit_ptr and pulse `frame_drop`.
- WR_FRAME, valid beat while full: `wr_ptr` <= commit_ptr and pulse `frame_drop`.
  - If the beat has tlast, stay in WR_FRAME.
  - Otherwise go to WR_DROP.
- WR_DROP: discard beats and return to WR_FRAME on a tlast beat; no second `frame_drop` pulse.
- Frames longer than 2**DEPTH_LOG2 beats are always dropped.
- Read side exposes only committed data (rd_ptr != commit_ptr). It uses a registered-output RAM plus a one-entry output register, giving AXI-Stream semantics with full throughput under continuous `m_axis_tready`.
- Pause FSM states: P_XON (reset state) and P_XOFF. `fifo_level` is the comparison value.
  - P_XON, level >= HI_WM: pulse `pause_req` with `pause_val`=PAUSE_QUANTA, load refresh counter with REFRESH_CYCLES−1, go to P_XOFF.
  - P_XOFF, level <= LO_WM: pulse `pause_req` with `pause_val`=0, go to P_XON. This takes priority over a refresh expiring in the same cycle.
  - P_XOFF, refresh counter == 0: re-pulse with PAUSE_QUANTA and reload the counter.
- A level exactly equal to a watermark counts as crossing it.

## Timing
- Reset values:
  - Outputs: m_axis_tvalid, m_axis_tlast, pause_req, frame_drop = 0; m_axis_tdata, m_axis_tkeep, pause_val = 0; fifo_level = 0.
  - Internal: all pointers 0; FSMs in WR_FRAME and P_XON; refresh counter 0.
- Reset mid-operation discards all stored data, committed and uncommitted; no `pause_req` is issued on reset.
- Commit to output: if the tlast beat is sampled at edge N and the buffer was empty, the first beat of that frame has `m_axis_tvalid` high after edge N+2.
- `m_axis_*` hold stable while tvalid=1 and tready=0.
- `fifo_level` updates one cycle after a write, read or rewind. Pause decisions use the registered level, so `pause_req` rises one cycle after the level crosses a watermark.
- Simultaneous write and read in one cycle: the level changes by the net amount; full is evaluated before the read.

## Configuration
- `XGMAC_RX_PAUSE_FIFO_STATS_EN` defined: adds outputs `frame_count` [31:0] (good frames committed) and `drop_count` [31:0] (`frame_drop` pulses). Both saturate at all-ones, reset to 0, and update one cycle after the event.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- `xgmac_pkg` holds:
  - the write FSM state type (WR_FRAME, WR_DROP);
  - the pause FSM state type (P_XON, P_XOFF);
  - the constant XGMAC_PAUSE_OFF = 16'h0000;
  - the keep-width function.
- Sub-module `xgmac_fifo_ram`: simple dual-port RAM with one clock, synchronous write, registered read, width DATA_WIDTH+DATA_WIDTH/8+1, depth 2**DEPTH_LOG2. All control logic lives in the top module.

## Test plan
- Good 8-beat frame (tuser=1), tready=1 → 8 beats out identical, tlast on beat 8, first tvalid after edge N+2, `frame_drop`=0.
- 8-beat frame with tuser=0 → nothing output, one `frame_drop` pulse, `fifo_level` back to 0.
- DEPTH_LOG2=4, tready=0, 20-beat frame → frame dropped, level returns to the prior committed value, and the next 4-beat good frame is delivered intact.
- HI_WM=12, LO_WM=4, tready=0, fill 12 beats → `pause_req` pulse with 16'hFFFF. Hold for REFRESH_CYCLES → a second pulse. Drain to 4 → pulse with 16'h0000.
- Refresh expiry and drop to LO_WM in the same cycle → a single pulse with 16'h0000.
- Reset asserted mid-frame with committed data pending → m_axis_tvalid=0 and fifo_level=0 next cycle; a clean frame after reset is delivered intact.
